// File: rtl/maxnet_pkg.sv
// Shared types for the maxnet operand driver: FSM states, default operand width,
// operand-set payload and the timeout-counter width helper.
package maxnet_pkg;

  localparam int unsigned DW_DEF = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  typedef struct packed {
    logic [DW_DEF-1:0] b3;
    logic [DW_DEF-1:0] b2;
    logic [DW_DEF-1:0] b1;
    logic [DW_DEF-1:0] b0;
  } opset_t;

  // Timeout counter is never narrower than 8 bits, wider when TMO needs it.
  function automatic int unsigned tmo_cw(input int unsigned tmo);
    int unsigned w;
    w = $clog2(tmo + 32'd1);
    return (w > 32'd8) ? w : 32'd8;
  endfunction

endpackage

// File: rtl/maxnet_set_fifo.sv
// Operand-set FIFO: DEPTH entries of payload_t, extra-MSB pointers so full and
// empty come from a single compare.
module maxnet_set_fifo
  import maxnet_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type payload_t = opset_t
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  payload_t din,
  output payload_t dout,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic          push_s, pop_s;
  payload_t      mem_q [DEPTH];

  assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty  = (wr_q == rd_q);
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign dout   = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = push_s ? (wr_q + PW'(1)) : wr_q;
    rd_d = pop_s  ? (rd_q + PW'(1)) : rd_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/maxnet_driver.sv
// Buffers operand sets, drives them to a compute core one at a time and holds each
// result for the consumer. MAXNET_DRIVER_TIMEOUT_EN adds a WAIT-state timeout.
module maxnet_driver
  import maxnet_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TMO   = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_b0,
  input  logic [DW-1:0] in_b1,
  input  logic [DW-1:0] in_b2,
  input  logic [DW-1:0] in_b3,
  output logic          core_start,
  output logic [DW-1:0] core_b0,
  output logic [DW-1:0] core_b1,
  output logic [DW-1:0] core_b2,
  output logic [DW-1:0] core_b3,
  input  logic          core_done,
  input  logic [DW-1:0] core_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic          out_err
);

  typedef struct packed {
    logic [DW-1:0] b3;
    logic [DW-1:0] b2;
    logic [DW-1:0] b1;
    logic [DW-1:0] b0;
  } set_t;

  state_e        state_q, state_d;
  set_t          in_set_s, head_s, ops_q, ops_d;
  logic          full_s, empty_s, pop_s;
  logic          first_q, first_d;
  logic          start_q, valid_q;
  logic [DW-1:0] res_q, res_d;
`ifdef MAXNET_DRIVER_TIMEOUT_EN
  localparam int unsigned CW = tmo_cw(TMO);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  assign in_set_s = '{b3: in_b3, b2: in_b2, b1: in_b1, b0: in_b0};

  maxnet_set_fifo #(.DEPTH(DEPTH), .payload_t(set_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop_s),
    .din   (in_set_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Next-state and datapath for the load/wait/hold sequence.
  always_comb begin
    state_d = state_q;
    ops_d   = ops_q;
    first_d = first_q;
    res_d   = res_q;
    pop_s   = 1'b0;
`ifdef MAXNET_DRIVER_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          ops_d   = head_s;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        first_d = 1'b1;
        state_d = S_WAIT;
`ifdef MAXNET_DRIVER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        // core_done may still be high from the previous run on the first WAIT cycle
        first_d = 1'b0;
`ifdef MAXNET_DRIVER_TIMEOUT_EN
        cnt_d   = cnt_q + CW'(1);
`endif
        if (!first_q && core_done) begin
          res_d   = core_result;
          state_d = S_HOLD;
`ifdef MAXNET_DRIVER_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
`ifdef MAXNET_DRIVER_TIMEOUT_EN
        else if (cnt_q == CW'(TMO - 32'd1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_HOLD;
        end
`endif
        else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; start/valid are registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ops_q   <= '0;
      first_q <= 1'b0;
      res_q   <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
`ifdef MAXNET_DRIVER_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ops_q   <= ops_d;
      first_q <= first_d;
      res_q   <= res_d;
      start_q <= (state_d == S_LOAD);
      valid_q <= (state_d == S_HOLD);
`ifdef MAXNET_DRIVER_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready   = !full_s;
  assign core_start = start_q;
  assign core_b0    = ops_q.b0;
  assign core_b1    = ops_q.b1;
  assign core_b2    = ops_q.b2;
  assign core_b3    = ops_q.b3;
  assign out_valid  = valid_q;
  assign out_result = res_q;
`ifdef MAXNET_DRIVER_TIMEOUT_EN
  assign out_err    = err_q;
`else
  assign out_err    = 1'b0;
`endif

endmodule

// File: tb/tb_maxnet_driver.sv
// Bench for maxnet_driver: a queue-based model of accepted sets and pending results,
// a max-of-four core model with programmable latency, and directed scenarios.
module tb_maxnet_driver;
  localparam int DW = 5, DEPTH = 4, TMO = 20;

  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_b0 = '0, in_b1 = '0, in_b2 = '0, in_b3 = '0;
  logic core_start, core_done = 1'b0;
  logic [DW-1:0] core_b0, core_b1, core_b2, core_b3, core_result = '0;
  logic out_valid, out_ready = 1'b1, out_err;
  logic [DW-1:0] out_result;

  always #5 clk = ~clk;

  maxnet_driver #(.DW(DW), .DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_b0(in_b0), .in_b1(in_b1), .in_b2(in_b2), .in_b3(in_b3),
    .core_start(core_start), .core_b0(core_b0), .core_b1(core_b1),
    .core_b2(core_b2), .core_b3(core_b3), .core_done(core_done),
    .core_result(core_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err));

  typedef struct { int b0; int b1; int b2; int b3; } vec_t;
  typedef struct { int res; int err; } res_t;

  vec_t acc_q[$];
  res_t res_q[$];
  int   log_q[$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0, n_starts = 0, start_cyc = 0, rise_cyc = 0;
  bit   inflight = 0, prev_start = 0, prev_valid = 0;
  vec_t loaded;
  bit   core_hang = 0, sticky = 0;
  int   lat = 6;

  function automatic int max4(input vec_t v);
    int m;
    m = v.b0;
    if (v.b1 > m) m = v.b1;
    if (v.b2 > m) m = v.b2;
    if (v.b3 > m) m = v.b3;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Core: result is the max of the four operands, done after lat edges (1 when sticky).
  initial begin
    bit st; vec_t v; int cnt; int cres; bit pending;
    pending = 0; cnt = 0; cres = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        pending = 0; cnt = 0; core_done = 1'b0; core_result = '0;
      end else begin
        st = core_start;
        v  = '{int'(core_b0), int'(core_b1), int'(core_b2), int'(core_b3)};
        #1;
        if (st) begin
          pending = 1; cres = max4(v); cnt = sticky ? 1 : lat;
          if (!sticky) core_done = 1'b0;
        end else if (pending && !core_hang) begin
          if (cnt > 1) cnt--;
          else begin
            core_done = 1'b1; core_result = DW'(cres); pending = 0;
          end
        end
      end
    end
  end

  // Compare process: checks every cycle against the queue model, then books this edge's handshakes.
  initial begin
    vec_t e; res_t r;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        acc_q.delete(); res_q.delete(); inflight = 0; prev_start = 0; prev_valid = 0;
      end else begin
        if (core_start) begin
          chk("start_pulse", {31'd0, prev_start}, 32'd0);
          n_starts++; start_cyc = cyc;
          if (acc_q.size() == 0) begin
            chk("start_without_set", 32'd1, 32'd0);
          end else begin
            e = acc_q.pop_front();
            chk("core_ops", {core_b3, core_b2, core_b1, core_b0}, {DW'(e.b3), DW'(e.b2), DW'(e.b1), DW'(e.b0)});
`ifdef MAXNET_DRIVER_TIMEOUT_EN
            r = core_hang ? '{0, 1} : '{max4(e), 0};
`else
            r = '{max4(e), 0};
`endif
            res_q.push_back(r); loaded = e; inflight = 1;
          end
        end else if (inflight) begin
          chk("ops_stable", {core_b3, core_b2, core_b1, core_b0}, {DW'(loaded.b3), DW'(loaded.b2), DW'(loaded.b1), DW'(loaded.b0)});
        end
        chk("in_ready", {31'd0, in_ready}, (acc_q.size() < DEPTH) ? 32'd1 : 32'd0);
        if (out_valid) begin
          if (!prev_valid) rise_cyc = cyc;
          if (res_q.size() == 0) chk("valid_without_result", 32'd1, 32'd0);
          else begin
            chk("out_result", {27'd0, out_result}, res_q[0].res);
            chk("out_err", {31'd0, out_err}, res_q[0].err);
          end
        end else begin
          chk("out_err_idle", {31'd0, out_err}, 32'd0);
        end
        prev_start = core_start; prev_valid = out_valid;
        if (in_valid && in_ready) acc_q.push_back('{int'(in_b0), int'(in_b1), int'(in_b2), int'(in_b3)});
        if (out_valid && out_ready && res_q.size() > 0) begin
          log_q.push_back(res_q[0].res); void'(res_q.pop_front()); inflight = 0;
        end
      end
    end
  end

  task automatic push(input int a, input int b, input int c, input int d);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_b0 = DW'(a); in_b1 = DW'(b); in_b2 = DW'(c); in_b3 = DW'(d);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) chk("push_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1;
    end
    if (!ok) chk("valid_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input int bound);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (acc_q.size() == 0 && res_q.size() == 0 && !out_valid) ok = 1;
    end
    if (!ok) chk("drain_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int idx, s0;
    logic [DW-1:0] held;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_core_start", {31'd0, core_start}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", {27'd0, out_result}, 32'd0);
    chk("rst_core_b", {core_b3, core_b2, core_b1, core_b0}, 20'd0);
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk); #1;

    // single set, latency 6
    idx = log_q.size(); s0 = n_starts;
    push(3, 2, 1, 5);
    wait_drain(100);
    chk("t1_starts", n_starts - s0, 32'd1);
    chk("t1_count", log_q.size() - idx, 32'd1);
    if (log_q.size() > idx) chk("t1_result", log_q[idx], 32'd5);
    chk("t1_latency", rise_cyc - start_cyc, 32'd8);

    // core_done left high from previous run
    sticky = 1; idx = log_q.size();
    push(7, 9, 4, 6);
    wait_drain(100);
    if (log_q.size() > idx) chk("t2_result", log_q[idx], 32'd9);
    chk("t2_latency", rise_cyc - start_cyc, 32'd3);
    sticky = 0;

    // consumer stall: fill FIFO behind a held result
    out_ready = 1'b0; idx = log_q.size();
    push(10, 1, 2, 3);
    wait_valid(50);
    push(1, 2, 3, 4);   chk("t3_ready1", {31'd0, in_ready}, 32'd1);
    push(31, 0, 0, 0);  chk("t3_ready2", {31'd0, in_ready}, 32'd1);
    push(0, 17, 0, 0);  chk("t3_ready3", {31'd0, in_ready}, 32'd1);
    push(0, 0, 0, 12);  chk("t3_ready4", {31'd0, in_ready}, 32'd0);
    held = out_result; s0 = n_starts;
    chk("t3_held_val", {27'd0, held}, 32'd10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_hold_result", {27'd0, out_result}, {27'd0, held});
    end
    chk("t3_no_start", n_starts - s0, 32'd0);
    @(posedge clk); #1; out_ready = 1'b1;
    wait_drain(400);
    chk("t3_count", log_q.size() - idx, 32'd5);
    if (log_q.size() >= idx + 5) begin
      chk("t3_order0", log_q[idx], 32'd10);
      chk("t3_order1", log_q[idx+1], 32'd4);
      chk("t3_order2", log_q[idx+2], 32'd31);
      chk("t3_order3", log_q[idx+3], 32'd17);
      chk("t3_order4", log_q[idx+4], 32'd12);
    end

    // core never completes
    core_hang = 1; idx = log_q.size();
    push(2, 8, 3, 1);
`ifdef MAXNET_DRIVER_TIMEOUT_EN
    wait_valid(80);
    chk("t4_latency", rise_cyc - start_cyc, 32'd21);
    chk("t4_err", {31'd0, out_err}, 32'd1);
    chk("t4_result", {27'd0, out_result}, 32'd0);
    wait_drain(20);
`else
    repeat (40) @(negedge clk);
    chk("t4_no_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_no_err", {31'd0, out_err}, 32'd0);
    @(posedge clk); #1; core_hang = 0;
    wait_drain(40);
    if (log_q.size() > idx) chk("t4_result", log_q[idx], 32'd8);
`endif
    core_hang = 0;

    // reset during WAIT with two sets buffered
    lat = 30;
    push(1, 1, 1, 1); push(2, 2, 2, 2); push(3, 3, 3, 3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_buffered", acc_q.size(), 32'd2);
    @(posedge clk); #3; rst = 1'b0; #1;
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_core_start", {31'd0, core_start}, 32'd0);
    chk("t5_core_b", {core_b3, core_b2, core_b1, core_b0}, 20'd0);
    chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_out_result", {27'd0, out_result}, 32'd0);
    chk("t5_out_err", {31'd0, out_err}, 32'd0);
    @(posedge clk); #1; rst = 1'b1; lat = 6; s0 = n_starts;
    repeat (20) @(negedge clk);
    chk("t5_post_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_post_starts", n_starts - s0, 32'd0);
    @(posedge clk); #1; idx = log_q.size();
    push(4, 5, 6, 0);
    wait_drain(100);
    if (log_q.size() > idx) chk("t5_result", log_q[idx], 32'd6);
    else chk("t5_count", log_q.size() - idx, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
